// File: rtl/service_scheduler_pkg.sv
// Shared definitions for the service scheduler: FSM encodings, default timing
// constants, the blank display word and the grant arbitration helper.
package service_scheduler_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE    = 2'b00,
    SCH_GRANT   = 2'b01,
    SCH_RELEASE = 2'b10
  } sch_state_t;

  localparam int          DEF_DEB_CYCLES = 500000;
  localparam int          DEF_TICK_DIV   = 1000000;
  localparam logic [15:0] BCD_BLANK      = 16'h0000;
  localparam int          MAX_SVC        = 4;

  // Lowest-index request wins when several switches are on together.
  function automatic logic [1:0] lowest_set(input logic [MAX_SVC-1:0] req);
    logic [1:0] idx;
    idx = '0;
    for (int i = MAX_SVC - 1; i >= 0; i--) begin
      if (req[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw button, accepts a level change only after DEB_CYCLES
// consecutive stable samples, and emits a one-cycle pulse on each accepted press.
module button_debouncer
  import service_scheduler_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             btn_p0;
  logic             btn_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_p0   <= 1'b0;
      btn_p1   <= 1'b0;
      level    <= 1'b0;
      cnt      <= '0;
      btn_rise <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchronizer
      btn_p0   <= btn_raw;
      btn_p1   <= btn_p0;
      btn_rise <= 1'b0;
      // stage p1 -> level: stability counter
      if (btn_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt      <= '0;
        level    <= ~level;
        btn_rise <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/service_scheduler.sv
// Grants the shared button, time-base and display to one service at a time,
// selected by its switch, without preemption.
module service_scheduler
  import service_scheduler_pkg::*;
#(
  parameter int NSVC       = 4,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSVC-1:0]    spdt,
  input  logic               push_m,
  input  logic [16*NSVC-1:0] disp_in,
  output logic [NSVC-1:0]    svc_en,
  output logic [NSVC-1:0]    push_pulse,
  output logic               tick,
  output logic [1:0]         active_id,
  output logic               busy,
  output logic [15:0]        disp_out
);

  localparam int                TCNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(TICK_DIV - 1);

  logic [NSVC-1:0]    spdt_p0;
  logic [NSVC-1:0]    spdt_p1;
  logic [MAX_SVC-1:0] req;
  sch_state_t         state;
  sch_state_t         state_nxt;
  logic [1:0]         id_nxt;
  logic [TCNT_W-1:0]  tick_cnt;
  logic               btn_rise;
  logic               grant;
  logic [15:0]        disp_sel;

  button_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_push_deb (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (push_m),
    .btn_rise (btn_rise)
  );

  assign req   = MAX_SVC'(spdt_p1);
  assign grant = (state == SCH_GRANT);
  assign busy  = grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      spdt_p0   <= '0;
      spdt_p1   <= '0;
      state     <= SCH_IDLE;
      active_id <= '0;
    end else begin
      // stage p0 -> p1: switch synchronizer
      spdt_p0   <= spdt;
      spdt_p1   <= spdt_p0;
      state     <= state_nxt;
      active_id <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = active_id;
    case (state)
      SCH_IDLE: begin
        if (|req) begin
          state_nxt = SCH_GRANT;
          id_nxt    = lowest_set(req);
        end
      end
      SCH_GRANT: begin
        if (!req[active_id]) state_nxt = SCH_RELEASE;
      end
      SCH_RELEASE: state_nxt = SCH_IDLE;
      default:     state_nxt = SCH_IDLE;
    endcase
  end

  // The divider restarts on every grant so the first tick lands TICK_DIV
  // cycles after svc_en rises; tick is suppressed on the cycle the grant ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= grant && (state_nxt == SCH_GRANT) && (tick_cnt == TICK_LAST);
      if (!grant) begin
        tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    disp_sel   = BCD_BLANK;
    svc_en     = '0;
    push_pulse = '0;
    for (int i = 0; i < NSVC; i++) begin
      if (active_id == 2'(i)) begin
        disp_sel      = disp_in[16*i +: 16];
        svc_en[i]     = grant;
        push_pulse[i] = grant && btn_rise;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_out <= BCD_BLANK;
    end else begin
      disp_out <= grant ? disp_sel : BCD_BLANK;
    end
  end

endmodule
